// File: rtl/digit_sequencer_if.sv
// Bus bundle between the digit_sequencer and its controller.
// The slave side (sequencer) takes load/clear/run/rate and drives the display and status signals.
interface digit_sequencer_if #(
    parameter int DEPTH = 8
);
    localparam int LW = $clog2(DEPTH + 1);

    logic          load;
    logic [3:0]    wr_data;
    logic          clear;
    logic          run;
    logic [2:0]    rate;
    logic [3:0]    hex;
    logic [LW-1:0] len;
    logic          full;
    logic          playing;
    logic          wrap;

    modport master (
        output load, wr_data, clear, run, rate,
        input  hex, len, full, playing, wrap
    );

    modport slave (
        input  load, wr_data, clear, run, rate,
        output hex, len, full, playing, wrap
    );
endinterface

// File: rtl/digit_sequencer.sv
// Message-playback stage feeding a seg7hex decoder: stores up to DEPTH symbol
// codes and steps through them at (rate+1) base ticks per symbol while run is high.
// Optional build macro SEQ_GAP_EN: blank the last base tick of each step when rate_s >= 1.
module digit_sequencer #(
    parameter int DEPTH       = 8,
    parameter int TICK_CYCLES = 1000
) (
    input logic             clk,
    input logic             reset,
    digit_sequencer_if.slave bus
);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(TICK_CYCLES);

    typedef enum logic {IDLE, PLAY} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [LW-1:0] len_q, len_d;
    logic          full_q, full_d;
    logic [CW-1:0] pre_q, pre_d;
    logic [2:0]    tick_q, tick_d;
    logic [2:0]    rate_s_q, rate_s_d;
    logic          wrap_q, wrap_d;

    logic [3:0]    mem [DEPTH];
    logic          mem_we;
    logic [PW-1:0] mem_waddr;

    logic          prescale_done;
    logic          step_done;
    logic          last_slot;
    logic          gap;

    // State register: all control state resets asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            len_q    <= '0;
            full_q   <= 1'b0;
            pre_q    <= '0;
            tick_q   <= '0;
            rate_s_q <= '0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            len_q    <= len_d;
            full_q   <= full_d;
            pre_q    <= pre_d;
            tick_q   <= tick_d;
            rate_s_q <= rate_s_d;
            wrap_q   <= wrap_d;
        end
    end

    // Message storage; contents are meaningless while len is zero, so no reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= bus.wr_data;
        end
    end

    // Next-state logic: clear beats run/state handling, which beats load
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        len_d     = len_q;
        pre_d     = pre_q;
        tick_d    = tick_q;
        rate_s_d  = rate_s_q;
        wrap_d    = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = PW'(len_q);

        prescale_done = (pre_q == CW'(TICK_CYCLES - 1));
        step_done     = prescale_done && (tick_q == rate_s_q);
        last_slot     = (LW'(ptr_q) == (len_q - LW'(1)));

        if (bus.clear) begin
            state_d = IDLE;
            ptr_d   = '0;
            len_d   = '0;
            pre_d   = '0;
            tick_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.run && (len_q != '0)) begin
                        state_d  = PLAY;
                        ptr_d    = '0;
                        pre_d    = '0;
                        tick_d   = '0;
                        rate_s_d = bus.rate;
                    end else if (bus.load && !full_q) begin
                        mem_we = 1'b1;
                        len_d  = len_q + LW'(1);
                    end
                end
                PLAY: begin
                    if (!bus.run) begin
                        state_d = IDLE;
                        ptr_d   = '0;
                        pre_d   = '0;
                        tick_d  = '0;
                    end else begin
                        pre_d = prescale_done ? '0 : pre_q + CW'(1);
                        if (step_done) begin
                            tick_d   = '0;
                            rate_s_d = bus.rate;
                            if (last_slot) begin
                                ptr_d  = '0;
                                wrap_d = 1'b1;
                            end else begin
                                ptr_d = ptr_q + PW'(1);
                            end
                        end else if (prescale_done) begin
                            tick_d = tick_q + 3'd1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        full_d = (len_d == LW'(DEPTH));
    end

    // Output logic: hex is blank outside PLAY and during the optional gap tick
    always_comb begin
`ifdef SEQ_GAP_EN
        gap = (rate_s_q != '0) && (tick_q == rate_s_q);
`else
        gap = 1'b0;
`endif
        bus.hex     = ((state_q == PLAY) && !gap) ? mem[ptr_q] : 4'hF;
        bus.len     = len_q;
        bus.full    = full_q;
        bus.playing = (state_q == PLAY);
        bus.wrap    = wrap_q;
    end
endmodule
